// File: rtl/key_cond_pkg.sv
// Shared timing defaults, repeat-state encoding and counter sizing for the
// pushbutton conditioning front end.
package key_cond_pkg;

    localparam int DEBOUNCE_10MS = 500_000;
    localparam int REPEAT_0P5S   = 25_000_000;
    localparam int RATE_0P1S     = 5_000_000;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rep_state_t;

    // One spare bit above the largest timing constant so counters never wrap.
    function automatic int cnt_width(input int debounce, input int delay, input int rate);
        int largest;
        largest = debounce;
        if (delay > largest) largest = delay;
        if (rate > largest) largest = rate;
        return $clog2(largest) + 1;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One pushbutton: two-flop synchronizer, debounce counter, press/release
// pulses and the auto-repeat state machine.
module key_channel
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int REPEAT_DELAY    = REPEAT_0P5S,
    parameter int REPEAT_RATE     = RATE_0P1S
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);

    logic [1:0]    sync;
    logic          sample;
    logic          toggle;
    logic          level_next;
    logic [CW-1:0] db_cnt;
    logic [CW-1:0] rep_cnt;
    rep_state_t    state;

    // Synchronizer reset to "released" so a held key is seen as a fresh press.
    // NOTE: every clocked block uses <= so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], key_n};
    end

    assign sample = ~sync[1];

    // NOTE: both combinational outputs are assigned on every path, so no latch.
    always_comb begin
        toggle     = (sample != level) && (db_cnt == CW'(DEBOUNCE_CYCLES - 1));
        level_next = toggle ? sample : level;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt        <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            level         <= level_next;
            press_pulse   <= toggle & sample;
            release_pulse <= toggle & ~sample;
            if ((sample == level) || toggle) db_cnt <= '0;
            else if (db_cnt != '1)           db_cnt <= db_cnt + 1'b1;
        end
    end

    // The FSM looks at level_next so the first repeat coincides with the press
    // pulse and nothing fires in the cycle the release is reported.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rep_cnt      <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (toggle && sample) begin
                        repeat_pulse <= 1'b1;
                        rep_cnt      <= CW'(1);
                        state        <= DELAY;
                    end
                end
                DELAY: begin
                    if (!level_next) begin
                        rep_cnt <= '0;
                        state   <= IDLE;
                    end else if (rep_cnt == CW'(REPEAT_DELAY)) begin
                        repeat_pulse <= 1'b1;
                        rep_cnt      <= CW'(1);
                        state        <= REPEAT;
                    end else if (rep_cnt != '1) begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!level_next) begin
                        rep_cnt <= '0;
                        state   <= IDLE;
                    end else if (rep_cnt == CW'(REPEAT_RATE)) begin
                        repeat_pulse <= 1'b1;
                        rep_cnt      <= CW'(1);
                    end else if (rep_cnt != '1) begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
                default: begin
                    rep_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Turns the raw active-low DE1-SoC KEY buttons into debounced levels and
// single-cycle press/release/repeat events on CLOCK_50.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int REPEAT_DELAY    = REPEAT_0P5S,
    parameter int REPEAT_RATE     = RATE_0P1S
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic                any_press
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_chan (
            .clk          (CLOCK_50),
            .reset        (reset),
            .key_n        (KEY[i]),
            .level        (key_level[i]),
            .press_pulse  (key_press[i]),
            .release_pulse(key_release[i]),
            .repeat_pulse (key_repeat[i])
        );
    end

    // key_press is already registered, so the OR stays a one-cycle pulse.
    assign any_press = |key_press;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed and randomized stimulus for key_conditioner, checked every cycle
// against an event-level model of debounce, pulses and auto-repeat.
module tb_key_conditioner;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] KEY;
    logic [N-1:0] key_level, key_press, key_release, key_repeat;
    logic         any_press;

    int checks = 0;
    int errors = 0;

    key_conditioner #(
        .NUM_KEYS       (N),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .KEY        (KEY),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_repeat (key_repeat),
        .any_press  (any_press)
    );

    always #5 clk = ~clk;

    // Model state: raw KEY/reset history at the last two edges, accepted level,
    // length of the current run of samples disagreeing with it, press edge.
    int           cyc = 0;
    logic [N-1:0] key_h1 = '1, key_h2 = '1;
    logic         rst_h1 = 1'b1, rst_h2 = 1'b1;
    logic [N-1:0] m_level = '0, m_press = '0, m_release = '0, m_repeat = '0;
    int           run[N];
    int           press_at[N];

    task automatic model_step(input logic [N-1:0] k, input logic r);
        logic s;
        int   age;
        cyc++;
        for (int i = 0; i < N; i++) begin
            // The debouncer sees KEY as it was two edges ago, or "released"
            // if reset was applied at either of those edges.
            s = (rst_h1 || rst_h2) ? 1'b0 : ~key_h2[i];
            m_press[i]   = 1'b0;
            m_release[i] = 1'b0;
            m_repeat[i]  = 1'b0;
            if (r) begin
                m_level[i] = 1'b0;
                run[i]     = 0;
            end else begin
                if (s != m_level[i]) run[i]++;
                else                 run[i] = 0;
                if (run[i] == D) begin
                    m_level[i] = s;
                    run[i]     = 0;
                    if (s) begin
                        m_press[i]  = 1'b1;
                        press_at[i] = cyc;
                    end else begin
                        m_release[i] = 1'b1;
                    end
                end
                age = cyc - press_at[i];
                if (m_level[i] && (age == 0 || (age >= RD && (age - RD) % RR == 0)))
                    m_repeat[i] = 1'b1;
            end
        end
        key_h2 = key_h1;
        key_h1 = k;
        rst_h2 = rst_h1;
        rst_h1 = r;
    endtask

    task automatic check(input string tag, input logic [N-1:0] observed, input logic [N-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, advance a clock edge, then compare all
    // outputs with the model away from the active edge.
    task automatic step(input logic [N-1:0] k, input logic r);
        KEY   = k;
        reset = r;
        @(posedge clk);
        model_step(k, r);
        @(negedge clk);
        check("key_level",   key_level,          m_level);
        check("key_press",   key_press,          m_press);
        check("key_release", key_release,        m_release);
        check("key_repeat",  key_repeat,         m_repeat);
        check("any_press",   {3'b000, any_press}, {3'b000, |m_press});
    endtask

    initial begin
        logic [N-1:0] k;
        int           bouncy;
        for (int i = 0; i < N; i++) begin
            run[i]      = 0;
            press_at[i] = -1000;
        end
        KEY   = '1;
        reset = 1'b1;
        @(negedge clk);

        // Reset for three cycles, then idle for fifty.
        for (int t = 0; t < 3; t++) step(4'hF, 1'b1);
        check("reset_level", key_level, 4'b0000);
        for (int t = 0; t < 50; t++) step(4'hF, 1'b0);
        check("idle_level", key_level, 4'b0000);

        // KEY[0] and KEY[3] pressed together.
        for (int t = 0; t < 5; t++) step(4'b0110, 1'b0);
        check("pre_accept_level", key_level, 4'b0000);
        step(4'b0110, 1'b0);
        check("dual_level",  key_level,          4'b1001);
        check("dual_press",  key_press,          4'b1001);
        check("dual_repeat", key_repeat,         4'b1001);
        check("dual_any",    {3'b000, any_press}, 4'b0001);
        step(4'b0110, 1'b0);
        check("dual_press_end", key_press, 4'b0000);

        // KEY[1] bouncing every two cycles never gets accepted.
        for (int t = 0; t < 20; t++) step(((t / 2) % 2 == 0) ? 4'b0100 : 4'b0110, 1'b0);
        check("bounce_level", key_level & 4'b0010, 4'b0000);

        // Release 0/3, hold KEY[2] long enough for several repeats, release.
        for (int t = 0; t < 10; t++) step(4'b1111, 1'b0);
        for (int t = 0; t < 40; t++) step(4'b1011, 1'b0);
        check("hold_level", key_level, 4'b0100);
        for (int t = 0; t < 15; t++) step(4'b1111, 1'b0);
        check("released_level", key_level, 4'b0000);

        // Reset while KEY[3] is held: fresh press afterwards, no release.
        for (int t = 0; t < 6; t++) step(4'b0111, 1'b0);
        check("pre_reset_level", key_level, 4'b1000);
        step(4'b0111, 1'b1);
        check("mid_reset_level", key_level, 4'b0000);
        check("mid_reset_release", key_release, 4'b0000);
        for (int t = 0; t < 5; t++) step(4'b0111, 1'b0);
        check("post_reset_wait", key_press, 4'b0000);
        step(4'b0111, 1'b0);
        check("post_reset_press", key_press, 4'b1000);
        for (int t = 0; t < 10; t++) step(4'b1111, 1'b0);

        // Randomized: alternating bouncy and calm windows, rare resets.
        k = 4'hF;
        bouncy = 0;
        for (int t = 0; t < 3000; t++) begin
            if (t % 200 == 0) bouncy = ($urandom_range(0, 1) == 1) ? 1 : 0;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 99) < (bouncy ? 30 : 3)) k[i] = ~k[i];
            step(k, ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
